// File: rtl/ball_pkg.sv
// ball_pkg: shared constants, FSM states and hit-side flags for the ball collision responder.
package ball_pkg;
   localparam int FIXED_POINT_SHIFT = 6;
   localparam int LEFT_EDGE = 0;
   localparam int RIGHT_EDGE = 639;
   localparam int TOP_EDGE = 0;
   localparam int BOTTOM_EDGE = 479;
   localparam int SPEED_W = 10;
   localparam int POS_W = 18;
   typedef enum logic [1:0] {S_COLLECT, S_SPEED, S_MOVE} state_t;
   typedef struct packed {
      logic top;
      logic bot;
      logic left;
      logic right;
      logic paddle;
   } hit_sides_t;
   function automatic logic signed [SPEED_W-1:0] sabs(input logic signed [SPEED_W-1:0] v);
      return v < 0 ? -v : v;
   endfunction
   function automatic logic signed [SPEED_W-1:0] clamp_speed(input int v, input int max_speed);
      return SPEED_W'(v > max_speed ? max_speed : v < -max_speed ? -max_speed : v);
   endfunction
endpackage

// File: rtl/hit_side_classifier.sv
// hit_side_classifier: maps the current scan pixel to the ball face(s) it lies on.
module hit_side_classifier
   import ball_pkg::*;
#(
   parameter int BALL_SIZE = 16,
   parameter int EDGE_BAND = 4
) (
   input  logic [10:0]        pixelX,
   input  logic [10:0]        pixelY,
   input  logic signed [10:0] topLeftX,
   input  logic signed [10:0] topLeftY,
   input  logic               hit_paddle,
   output hit_sides_t         sides
);
   logic signed [11:0] dx, dy;
   assign dx = $signed({1'b0, pixelX}) - $signed({topLeftX[10], topLeftX});
   assign dy = $signed({1'b0, pixelY}) - $signed({topLeftY[10], topLeftY});
   assign sides.top = int'(dy) < EDGE_BAND;
   assign sides.bot = int'(dy) >= BALL_SIZE - EDGE_BAND;
   assign sides.left = int'(dx) < EDGE_BAND;
   assign sides.right = int'(dx) >= BALL_SIZE - EDGE_BAND;
   assign sides.paddle = hit_paddle;
endmodule

// File: rtl/ball_collision_responder.sv
// ball_collision_responder: accumulates per-pixel ball hits, bounces and moves the ball once per frame.
// Optional paddle spin (X kick from paddle hit offset) is built when PADDLE_SPIN_EN is defined.
module ball_collision_responder
   import ball_pkg::*;
#(
   parameter int INITIAL_X = 280,
   parameter int INITIAL_Y = 185,
   parameter int INITIAL_X_SPEED = 40,
   parameter int INITIAL_Y_SPEED = -20,
   parameter int BALL_SIZE = 16,
   parameter int EDGE_BAND = 4,
   parameter int MAX_SPEED = 255
) (
   input  logic                      clk,
   input  logic                      resetN,
   input  logic                      startOfFrame,
   input  logic                      collision,
   input  logic                      hit_paddle,
   input  logic [10:0]               pixelX,
   input  logic [10:0]               pixelY,
   output logic signed [10:0]        topLeftX,
   output logic signed [10:0]        topLeftY,
   output logic signed [SPEED_W-1:0] Xspeed,
   output logic signed [SPEED_W-1:0] Yspeed,
   output logic                      bounce_pulse
);
   state_t state, next_state;
   hit_sides_t sides, hit_now, acc, app;
   logic signed [POS_W-1:0] posX, posY;
   logic signed [SPEED_W-1:0] x_face, x_wall, y_face, y_wall, x_next, y_next;
   logic take, bounce_next;
   int spin;
   hit_side_classifier #(.BALL_SIZE(BALL_SIZE), .EDGE_BAND(EDGE_BAND)) u_classifier (
      .pixelX(pixelX),
      .pixelY(pixelY),
      .topLeftX(topLeftX),
      .topLeftY(topLeftY),
      .hit_paddle(hit_paddle),
      .sides(sides)
   );
   assign take = (state == S_COLLECT) && startOfFrame;
   assign topLeftX = posX[FIXED_POINT_SHIFT +: 11];
   assign topLeftY = posY[FIXED_POINT_SHIFT +: 11];
   always_comb begin
      hit_now = collision ? sides : '0;
      hit_now.paddle = hit_paddle;
   end
   always_ff @(posedge clk or negedge resetN)
      if (!resetN) state <= S_COLLECT;
      else state <= next_state;
   always_comb
      next_state = take ? S_SPEED : (state == S_SPEED) ? S_MOVE : (state == S_MOVE) ? S_COLLECT : state;
`ifdef PADDLE_SPIN_EN
   logic [10:0] acc_hitX, app_hitX;
   always_ff @(posedge clk or negedge resetN)
      if (!resetN) begin
         acc_hitX <= '0;
         app_hitX <= '0;
      end else if (take) begin
         app_hitX <= acc_hitX;
         if (hit_paddle) acc_hitX <= pixelX;
      end else if (hit_paddle && !acc.paddle) acc_hitX <= pixelX;
   assign spin = app.paddle ? (int'(app_hitX) - int'(topLeftX) - BALL_SIZE / 2) <<< 2 : 0;
`else
   assign spin = 0;
`endif
   // Sign forcing only: a ball already leaving a face or wall keeps its direction.
   always_comb begin
      x_face = (app.left && !app.right) ? sabs(Xspeed) : (app.right && !app.left) ? -sabs(Xspeed) : Xspeed;
      x_wall = (int'(topLeftX) <= LEFT_EDGE) ? sabs(x_face) : (int'(topLeftX) + BALL_SIZE > RIGHT_EDGE) ? -sabs(x_face) : x_face;
      y_face = app.paddle ? -sabs(Yspeed) : (app.top && !app.bot) ? sabs(Yspeed) : (app.bot && !app.top) ? -sabs(Yspeed) : Yspeed;
      y_wall = (int'(topLeftY) <= TOP_EDGE) ? sabs(y_face) : (int'(topLeftY) + BALL_SIZE > BOTTOM_EDGE) ? -sabs(y_face) : y_face;
      x_next = clamp_speed(int'(x_wall) + spin, MAX_SPEED);
      y_next = clamp_speed(int'(y_wall), MAX_SPEED);
      bounce_next = (x_next[SPEED_W-1] != Xspeed[SPEED_W-1]) || (y_next[SPEED_W-1] != Yspeed[SPEED_W-1]);
   end
   always_ff @(posedge clk or negedge resetN)
      if (!resetN) begin
         acc <= '0;
         app <= '0;
         Xspeed <= SPEED_W'(INITIAL_X_SPEED);
         Yspeed <= SPEED_W'(INITIAL_Y_SPEED);
         posX <= POS_W'(INITIAL_X <<< FIXED_POINT_SHIFT);
         posY <= POS_W'(INITIAL_Y <<< FIXED_POINT_SHIFT);
         bounce_pulse <= 1'b0;
      end else begin
         acc <= (take ? '0 : acc) | hit_now;
         if (take) app <= acc;
         bounce_pulse <= (state == S_SPEED) && bounce_next;
         if (state == S_SPEED) begin
            Xspeed <= x_next;
            Yspeed <= y_next;
         end
         if (state == S_MOVE) begin
            posX <= posX + POS_W'(Xspeed);
            posY <= posY + POS_W'(Yspeed);
         end
      end
endmodule
